// File: rtl/mmu_param.sv
// Data/instruction MMU for the RV32I softcore: routes core requests to a byte-lane
// data RAM, a word-wide IO bus with ready/timeout, or the instruction ROM.
module mmu_param #(
  parameter logic [31:0] DM_BASE       = 32'h1000_0000,
  parameter int          DM_DEPTH_LOG2 = 10,
  parameter logic [31:0] IO_BASE       = 32'h8000_0000,
  parameter int          IO_ADDR_W     = 8,
  parameter int          IM_DEPTH_LOG2 = 12,
  parameter int          IO_TIMEOUT    = 15
) (
  input  logic                     clk,
  input  logic                     resetb,
  input  logic [31:0]              im_addr,
  output logic [IM_DEPTH_LOG2-1:0] im_rom_addr,
  input  logic [31:0]              im_rom_data,
  output logic [31:0]              im_do,
  output logic                     im_fault,
  input  logic                     dm_en,
  input  logic                     dm_we,
  input  logic [31:0]              dm_addr,
  input  logic [31:0]              dm_di,
  input  logic [3:0]               dm_be,
  input  logic                     dm_signed,
  output logic [31:0]              dm_do,
  output logic                     dm_valid,
  output logic                     dm_fault,
  output logic                     dm_stall,
  output logic                     io_en,
  output logic                     io_we,
  output logic [IO_ADDR_W-1:0]     io_addr,
  output logic [31:0]              io_data_write,
  output logic [3:0]               io_be,
  input  logic [31:0]              io_data_read,
  input  logic                     io_ready
);

  localparam logic [0:0]  S_IDLE  = 1'b0;
  localparam logic [0:0]  S_WAIT  = 1'b1;
  localparam logic [32:0] DM_END  = {1'b0, DM_BASE} + (33'd4 << DM_DEPTH_LOG2);
  localparam logic [32:0] IO_END  = {1'b0, IO_BASE} + (33'd4 << IO_ADDR_W);
  localparam logic [32:0] IM_END  = 33'd4 << IM_DEPTH_LOG2;
  localparam logic [7:0]  TO_LAST = 8'(IO_TIMEOUT - 1);

  function automatic logic be_legal(input logic [3:0] be);
    case (be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111: be_legal = 1'b1;
      default: be_legal = 1'b0;
    endcase
  endfunction

  // Right-align the enabled lane(s) and extend from the top bit of that lane.
  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [3:0] be,
                                              input logic sgn);
    case (be)
      4'b0001: load_extend = {{24{sgn & w[7]}},  w[7:0]};
      4'b0010: load_extend = {{24{sgn & w[15]}}, w[15:8]};
      4'b0100: load_extend = {{24{sgn & w[23]}}, w[23:16]};
      4'b1000: load_extend = {{24{sgn & w[31]}}, w[31:24]};
      4'b0011: load_extend = {{16{sgn & w[15]}}, w[15:0]};
      4'b1100: load_extend = {{16{sgn & w[31]}}, w[31:16]};
      4'b1111: load_extend = w;
      default: load_extend = 32'h0;
    endcase
  endfunction

  logic [31:0] mem [2**DM_DEPTH_LOG2];

  logic [0:0]           state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [31:0]          dm_do_q, dm_do_d;
  logic                 valid_q, valid_d;
  logic                 fault_q, fault_d;
  logic                 io_en_q, io_en_d;
  logic                 io_we_q, io_we_d;
  logic [IO_ADDR_W-1:0] io_addr_q, io_addr_d;
  logic [31:0]          io_wdata_q, io_wdata_d;
  logic [3:0]           io_be_q, io_be_d;
  logic                 sgn_q, sgn_d;
  logic                 mem_we;
  logic                 dm_hit, io_hit, be_ok;
  logic [DM_DEPTH_LOG2-1:0] dm_idx;
  logic [31:0]          mem_rd;

  assign im_rom_addr = im_addr[IM_DEPTH_LOG2+1:2];
  assign im_do       = im_rom_data;
  assign im_fault    = (im_addr[1:0] != 2'b00) || ({1'b0, im_addr} >= IM_END);

  assign dm_hit = ({1'b0, dm_addr} >= {1'b0, DM_BASE}) && ({1'b0, dm_addr} < DM_END);
  assign io_hit = ({1'b0, dm_addr} >= {1'b0, IO_BASE}) && ({1'b0, dm_addr} < IO_END);
  assign be_ok  = be_legal(dm_be);
  assign dm_idx = dm_addr[DM_DEPTH_LOG2+1:2];
  assign mem_rd = mem[dm_idx];

  assign dm_do         = dm_do_q;
  assign dm_valid      = valid_q;
  assign dm_fault      = fault_q;
  assign dm_stall      = (state_q == S_WAIT);
  assign io_en         = io_en_q;
  assign io_we         = io_we_q;
  assign io_addr       = io_addr_q;
  assign io_data_write = io_wdata_q;
  assign io_be         = io_be_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dm_do_d    = dm_do_q;
    valid_d    = 1'b0;
    fault_d    = 1'b0;
    io_en_d    = io_en_q;
    io_we_d    = io_we_q;
    io_addr_d  = io_addr_q;
    io_wdata_d = io_wdata_q;
    io_be_d    = io_be_q;
    sgn_d      = sgn_q;
    mem_we     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dm_en) begin
          if (!be_ok || !(dm_hit || io_hit)) begin
            valid_d = 1'b1;
            fault_d = 1'b1;
            dm_do_d = 32'h0;
          end else if (dm_hit) begin
            valid_d = 1'b1;
            mem_we  = dm_we;
            dm_do_d = dm_we ? 32'h0 : load_extend(mem_rd, dm_be, dm_signed);
          end else begin
            io_en_d    = 1'b1;
            io_we_d    = dm_we;
            io_addr_d  = dm_addr[IO_ADDR_W+1:2];
            io_be_d    = dm_be;
            io_wdata_d = dm_di;
            sgn_d      = dm_signed;
            cnt_d      = 8'h0;
            state_d    = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // A ready arriving on the last allowed cycle still wins over the timeout.
        if (io_ready) begin
          io_en_d = 1'b0;
          valid_d = 1'b1;
          dm_do_d = io_we_q ? 32'h0 : load_extend(io_data_read, io_be_q, sgn_q);
          state_d = S_IDLE;
        end else if (cnt_q == TO_LAST) begin
          io_en_d = 1'b0;
          valid_d = 1'b1;
          fault_d = 1'b1;
          dm_do_d = 32'h0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'h0;
      dm_do_q    <= 32'h0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
      io_en_q    <= 1'b0;
      io_we_q    <= 1'b0;
      io_addr_q  <= '0;
      io_wdata_q <= 32'h0;
      io_be_q    <= 4'h0;
      sgn_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dm_do_q    <= dm_do_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
      io_en_q    <= io_en_d;
      io_we_q    <= io_we_d;
      io_addr_q  <= io_addr_d;
      io_wdata_q <= io_wdata_d;
      io_be_q    <= io_be_d;
      sgn_q      <= sgn_d;
    end
  end

  // RAM contents survive reset; only enabled lanes are written.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (dm_be[i]) mem[dm_idx][8*i +: 8] <= dm_di[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mmu_param.sv
// Scoreboard bench for mmu_param: table of DM vectors plus hand-written IO,
// timeout, reset-in-wait and instruction-side sequences.
module tb_mmu_param;

  logic        clk = 1'b0;
  logic        resetb;
  logic [31:0] im_addr;
  logic [11:0] im_rom_addr;
  logic [31:0] im_rom_data;
  logic [31:0] im_do;
  logic        im_fault;
  logic        dm_en, dm_we, dm_signed;
  logic [31:0] dm_addr, dm_di;
  logic [3:0]  dm_be;
  logic [31:0] dm_do;
  logic        dm_valid, dm_fault, dm_stall;
  logic        io_en, io_we;
  logic [7:0]  io_addr;
  logic [31:0] io_data_write;
  logic [3:0]  io_be;
  logic [31:0] io_data_read;
  logic        io_ready;

  mmu_param dut (
    .clk(clk), .resetb(resetb),
    .im_addr(im_addr), .im_rom_addr(im_rom_addr), .im_rom_data(im_rom_data),
    .im_do(im_do), .im_fault(im_fault),
    .dm_en(dm_en), .dm_we(dm_we), .dm_addr(dm_addr), .dm_di(dm_di), .dm_be(dm_be),
    .dm_signed(dm_signed), .dm_do(dm_do), .dm_valid(dm_valid), .dm_fault(dm_fault),
    .dm_stall(dm_stall),
    .io_en(io_en), .io_we(io_we), .io_addr(io_addr), .io_data_write(io_data_write),
    .io_be(io_be), .io_data_read(io_data_read), .io_ready(io_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        f;
    int          lat;
    int          acc;
    string       nm;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] di;
    logic [3:0]  be;
    logic        sgn;
    logic [31:0] exp_d;
    logic        exp_f;
    string       nm;
  } vec_t;

  exp_t sbq[$];
  vec_t vq[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Completion monitor: every dm_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (resetb === 1'b1) begin
      if (dm_valid) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: got do=%h fault=%b want no completion", dm_do, dm_fault);
        end else begin
          mon_e = sbq.pop_front();
          chk({mon_e.nm, "_do"}, dm_do, mon_e.d);
          chk({mon_e.nm, "_fault"}, {31'h0, dm_fault}, {31'h0, mon_e.f});
          if (mon_e.lat >= 0) chk({mon_e.nm, "_lat"}, cyc - mon_e.acc, mon_e.lat);
        end
      end else if (dm_fault) begin
        total++;
        bad++;
        $display("FAIL fault_without_valid: got fault=1 want 0");
      end
    end
  end

  task automatic req(input logic we, input logic [31:0] addr, input logic [31:0] di,
                     input logic [3:0] be, input logic sgn, input logic [31:0] ed,
                     input logic ef, input int lat, input string nm, input bit push);
    exp_t e;
    dm_en = 1'b1; dm_we = we; dm_addr = addr; dm_di = di; dm_be = be; dm_signed = sgn;
    @(posedge clk);
    #1;
    dm_en = 1'b0;
    if (push) begin
      e.d = ed; e.f = ef; e.lat = lat; e.acc = cyc; e.nm = nm;
      sbq.push_back(e);
    end
  endtask

  task automatic drain(input int budget, input string nm);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got %0d outstanding want 0", nm, sbq.size());
      sbq.delete();
    end
    @(negedge clk);
  endtask

  function automatic void addv(input logic we, input logic [31:0] addr, input logic [31:0] di,
                               input logic [3:0] be, input logic sgn, input logic [31:0] ed,
                               input logic ef, input string nm);
    vec_t v;
    v.we = we; v.addr = addr; v.di = di; v.be = be; v.sgn = sgn;
    v.exp_d = ed; v.exp_f = ef; v.nm = nm;
    vq.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc;
    int ec;
    resetb = 1'b0; dm_en = 1'b0; dm_we = 1'b0; dm_addr = 32'h0; dm_di = 32'h0;
    dm_be = 4'h0; dm_signed = 1'b0; io_data_read = 32'h0; io_ready = 1'b0;
    im_addr = 32'h0; im_rom_data = 32'h0;

    addv(1, 32'h1000_0000, 32'h0000_0000, 4'b1111, 0, 32'h0,         0, "clr_w0");
    addv(1, 32'h1000_0000, 32'h0000_00A5, 4'b0001, 0, 32'h0,         0, "st_b0");
    addv(0, 32'h1000_0000, 32'h0,         4'b0001, 0, 32'h0000_00A5, 0, "ld_bu");
    addv(0, 32'h1000_0000, 32'h0,         4'b0001, 1, 32'hFFFF_FFA5, 0, "ld_bs");
    addv(1, 32'h1000_0004, 32'h1234_5678, 4'b1111, 0, 32'h0,         0, "st_w");
    addv(1, 32'h1000_0004, 32'hBEEF_0000, 4'b1100, 0, 32'h0,         0, "st_hi");
    addv(0, 32'h1000_0004, 32'h0,         4'b1111, 1, 32'hBEEF_5678, 0, "ld_w");
    addv(0, 32'h1000_0004, 32'h0,         4'b1100, 1, 32'hFFFF_BEEF, 0, "ld_hs");
    addv(0, 32'h1000_0004, 32'h0,         4'b1100, 0, 32'h0000_BEEF, 0, "ld_hu");
    addv(0, 32'h1000_0004, 32'h0,         4'b0011, 1, 32'h0000_5678, 0, "ld_los");
    addv(0, 32'h1000_0004, 32'h0,         4'b0010, 1, 32'h0000_0056, 0, "ld_b1s");
    addv(0, 32'h1000_0004, 32'h0,         4'b1000, 1, 32'hFFFF_FFBE, 0, "ld_b3s");
    addv(0, 32'h2000_0000, 32'h0,         4'b1111, 0, 32'h0,         1, "unmapped");
    addv(0, 32'h1000_0000, 32'h0,         4'b0101, 0, 32'h0,         1, "ld_be0101");
    addv(1, 32'h1000_0000, 32'hFFFF_FFFF, 4'b0000, 0, 32'h0,         1, "st_be0000");
    addv(1, 32'h1000_0000, 32'hFFFF_FFFF, 4'b0101, 0, 32'h0,         1, "st_be0101");
    addv(0, 32'h1000_0000, 32'h0,         4'b1111, 0, 32'h0000_00A5, 0, "readback");
    addv(1, 32'h1000_0FFC, 32'h0000_0080, 4'b0001, 0, 32'h0,         0, "st_top");
    addv(0, 32'h1000_0FFC, 32'h0,         4'b0001, 1, 32'hFFFF_FF80, 0, "ld_top");
    addv(0, 32'h1000_1000, 32'h0,         4'b1111, 0, 32'h0,         1, "dm_end");
    addv(0, 32'h0FFF_FFFC, 32'h0,         4'b1111, 0, 32'h0,         1, "dm_below");
    addv(0, 32'h8000_0400, 32'h0,         4'b1111, 0, 32'h0,         1, "io_end");

    repeat (2) @(posedge clk);
    #1;
    chk("rst_do", dm_do, 32'h0);
    chk("rst_valid", {31'h0, dm_valid}, 32'h0);
    chk("rst_io_en", {31'h0, io_en}, 32'h0);
    chk("rst_io_addr", {24'h0, io_addr}, 32'h0);
    chk("rst_stall", {31'h0, dm_stall}, 32'h0);
    resetb = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      req(vq[i].we, vq[i].addr, vq[i].di, vq[i].be, vq[i].sgn, vq[i].exp_d, vq[i].exp_f,
          0, vq[i].nm, 1);
      drain(5, vq[i].nm);
    end

    // Back-to-back DM requests, one completion per cycle.
    req(1, 32'h1000_0008, 32'h1122_3344, 4'b1111, 0, 32'h0,         0, 0, "b2b_st", 1);
    req(0, 32'h1000_0008, 32'h0,         4'b1111, 0, 32'h1122_3344, 0, 0, "b2b_ld", 1);
    req(0, 32'h1000_0008, 32'h0,         4'b0100, 1, 32'h0000_0022, 0, 0, "b2b_b2", 1);
    drain(5, "b2b");

    // IO load, ready in the third wait cycle.
    io_data_read = 32'h0000_8000;
    req(0, 32'h8000_0010, 32'h0, 4'b0011, 1, 32'hFFFF_8000, 0, -1, "io_ld", 1);
    chk("io_en_on", {31'h0, io_en}, 32'h1);
    chk("io_addr", {24'h0, io_addr}, 32'h4);
    chk("io_we_ld", {31'h0, io_we}, 32'h0);
    chk("io_be", {28'h0, io_be}, 32'h3);
    sc = 0;
    repeat (3) begin
      @(negedge clk);
      if (dm_stall) sc++;
    end
    io_ready = 1'b1;
    @(posedge clk);
    #1;
    io_ready = 1'b0;
    chk("io_en_off", {31'h0, io_en}, 32'h0);
    @(negedge clk);
    if (dm_stall) sc++;
    chk("io_stall_cycles", sc, 3);
    drain(5, "io_ld");

    // IO store with no ready: times out after 15 wait cycles.
    req(1, 32'h8000_0020, 32'hCAFE_F00D, 4'b1111, 0, 32'h0, 1, -1, "io_to", 1);
    chk("io_wdata", io_data_write, 32'hCAFE_F00D);
    chk("io_we_st", {31'h0, io_we}, 32'h1);
    ec = 0;
    for (int k = 0; k < 40 && io_en; k++) begin
      @(negedge clk);
      if (io_en) ec++;
    end
    chk("io_to_cycles", ec, 15);
    drain(5, "io_to");
    req(0, 32'h1000_0004, 32'h0, 4'b1111, 0, 32'hBEEF_5678, 0, 0, "post_to", 1);
    drain(5, "post_to");

    // Ready on the final allowed cycle beats the timeout.
    io_data_read = 32'h0000_00F0;
    req(0, 32'h8000_0000, 32'h0, 4'b0001, 1, 32'hFFFF_FFF0, 0, -1, "io_edge", 1);
    repeat (15) @(negedge clk);
    io_ready = 1'b1;
    @(posedge clk);
    #1;
    io_ready = 1'b0;
    drain(5, "io_edge");

    // Reset while waiting on IO: no completion may appear.
    req(0, 32'h8000_0008, 32'h0, 4'b1111, 0, 32'h0, 0, -1, "io_rst", 0);
    repeat (3) @(negedge clk);
    resetb = 1'b0;
    @(posedge clk);
    #1;
    resetb = 1'b1;
    chk("rst_wait_io_en", {31'h0, io_en}, 32'h0);
    chk("rst_wait_stall", {31'h0, dm_stall}, 32'h0);
    ec = 0;
    repeat (20) begin
      @(negedge clk);
      if (dm_valid) ec++;
    end
    chk("rst_wait_no_valid", ec, 0);

    im_rom_data = 32'h0013_0313;
    im_addr = 32'h0000_0006;
    #1;
    chk("im_misalign", {31'h0, im_fault}, 32'h1);
    im_addr = 32'h0000_0008;
    #1;
    chk("im_rom_addr", {20'h0, im_rom_addr}, 32'h2);
    chk("im_ok", {31'h0, im_fault}, 32'h0);
    chk("im_do", im_do, 32'h0013_0313);
    im_addr = 32'h0000_3FFC;
    #1;
    chk("im_top", {31'h0, im_fault}, 32'h0);
    im_addr = 32'h0000_4000;
    #1;
    chk("im_end", {31'h0, im_fault}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmu_param.md
Name: mmu_param

Overview:
- Parametrised data/instruction memory management unit for the embedded RV32I softcore; successor to the fixed-map mmu.
- Decodes core addresses into three targets:
  - internal byte-lane-writable data RAM;
  - an external word-wide IO bus with ready handshake and timeout;
  - an external instruction ROM.
- Adds load sign/zero extension, a fault signal for unmapped or illegal accesses, and stall generation for slow IO.

Parameters:
- DM_BASE, 32'h10000000, byte base address of data RAM
- DM_DEPTH_LOG2, 10, log2 of data RAM depth in 32-bit words
- IO_BASE, 32'h80000000, byte base address of IO region
- IO_ADDR_W, 8, IO word-address width
- IM_DEPTH_LOG2, 12, log2 of instruction ROM depth in words
- IO_TIMEOUT, 15, maximum IO_WAIT cycles before fault (1..255)

Ports:
- clk  in  1  clock, all state on rising edge
- resetb  in  1  synchronous active-low reset
- im_addr  in  32  instruction byte address
- im_rom_addr  out  IM_DEPTH_LOG2  ROM word address = im_addr[IM_DEPTH_LOG2+1:2]
- im_rom_data  in  32  ROM data
- im_do  out  32  instruction, combinational pass-through of im_rom_data
- im_fault  out  1  im_addr[1:0]!=0 or im_addr >= 4*2^IM_DEPTH_LOG2 (combinational)
- dm_en  in  1  data request strobe
- dm_we  in  1  1=store, 0=load
- dm_addr  in  32  data byte address (bits [1:0] ignored; lanes chosen by dm_be)
- dm_di  in  32  store data, lane-aligned
- dm_be  in  4  byte enables
- dm_signed  in  1  load sign-extend when 1, zero-extend when 0
- dm_do  out  32  load result, right-aligned and extended
- dm_valid  out  1  one-cycle completion pulse
- dm_fault  out  1  one-cycle fault pulse, coincident with dm_valid
- dm_stall  out  1  core must hold its request
- io_en  out  1  IO access active
- io_we  out  1  IO write
- io_addr  out  IO_ADDR_W  IO word address
- io_data_write  out  32  IO write data
- io_be  out  4  IO byte enables
- io_data_read  in  32  IO read data
- io_ready  in  1  IO completion

Behaviour:

Reset (resetb=0 at an edge):
- state=IDLE.
- dm_do=0, dm_valid=0, dm_fault=0.
- io_en=0, io_we=0, io_addr=0, io_data_write=0, io_be=0.
- timeout counter=0.
- RAM contents are not reset.

Address decode:
- DM hit: DM_BASE <= addr < DM_BASE + 4*2^DM_DEPTH_LOG2.
- IO hit: IO_BASE <= addr < IO_BASE + 4*2^IO_ADDR_W.
- Anything else: unmapped.

Legal dm_be values:
- Bytes: 0001, 0010, 0100, 1000.
- Halves: 0011, 1100.
- Word: 1111.
- Any other value (including 0000) faults.

State IDLE:
- dm_stall=0. A request is accepted on any edge with dm_en=1.
- DM load: RAM read. Next cycle: dm_valid=1, dm_do = selected lane(s) shifted to bit 0, extended per dm_signed.
- DM store: only enabled lanes are written at this edge. Next cycle: dm_valid=1, dm_do=0.
- IO hit:
  - Register io_addr = addr[IO_ADDR_W+1:2]; register io_we, io_be, io_data_write.
  - io_en=1 from the next cycle.
  - Go to IO_WAIT and clear the counter.
- Unmapped address or illegal dm_be:
  - Next cycle: dm_valid=1, dm_fault=1, dm_do=0.
  - No RAM or IO side effect.
- Back-to-back DM requests complete at one per cycle.

State IO_WAIT:
- dm_stall=1 combinationally; dm_en is ignored.
- Each cycle with io_ready=0, the counter increments.
- Edge with io_ready=1:
  - io_en=0.
  - Load: dm_do = extend(io_data_read lanes).
  - Store: dm_do=0.
  - dm_valid=1 next cycle; return to IDLE.
- Counter reaches IO_TIMEOUT with io_ready=0:
  - io_en=0.
  - dm_valid=1, dm_fault=1, dm_do=0.
  - Return to IDLE.
- io_ready takes priority over timeout when both occur in the same cycle.

Other rules:
- dm_valid and dm_fault are single-cycle pulses; dm_do holds its value until the next completion.
- Reset while in IO_WAIT: io_en=0 after that edge, no dm_valid pulse, state=IDLE.
- Extension: byte loads extend bit 7; half loads extend bit 15; word loads are unaffected by dm_signed.

Test Plan:
1. Store 32'h000000A5 with be=0001 to 0x10000000, then load the same address: unsigned -> dm_do=32'h000000A5; signed -> 32'hFFFFFFA5; each dm_valid arrives 1 cycle after the request.
2. Store 32'h12345678 with be=1111 at 0x10000004, then store 32'hBEEF0000 with be=1100; load be=1111 -> 32'hBEEF5678; signed be=1100 load -> 32'hFFFFBEEF.
3. Load from 0x80000010 with io_ready asserted 3 cycles after io_en and io_data_read=32'h00008000, be=0011 signed:
   - io_addr=8'h04;
   - dm_stall high for 3 cycles;
   - dm_do=32'hFFFF8000.
4. IO store with io_ready held 0: after IO_TIMEOUT=15 cycles io_en drops; dm_valid=dm_fault=1; dm_do=0; the next DM request is accepted normally.
5. Load from 0x20000000, and load with be=0101 at 0x10000000: each gives dm_fault=1, dm_do=0; RAM word unchanged on read-back.
6. Assert reset mid IO_WAIT: io_en=0 after that edge, no dm_valid pulse; im_addr=0x00000006 -> im_fault=1; im_addr=0x00000008 -> im_rom_addr=2.
